video_sync: RTL and testbench
=============================

Name: video_sync

Overview:
- Free-running raster timing generator for a 640x480@60 Hz display mode (800x525 total) by default.
- Produces the pixel position (x, y), the blanking indicator, and the horizontal and vertical sync pulses.
- One pixel per clock; the clock is the pixel clock.
- Feeds pixel generators and the TMDS/DVI encoder downstream.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_SYNC_POL, 0, asserted level of h_sync (0 = active-low)
- V_SYNC_POL, 0, asserted level of v_sync (0 = active-low)

Ports:
- clk  input  1  pixel clock; all logic on rising edge
- rst  input  1  reset; asynchronous, active-low
- blanking  output  1  1 when (x, y) is outside the visible area
- h_sync  output  1  horizontal sync, polarity per H_SYNC_POL
- v_sync  output  1  vertical sync, polarity per V_SYNC_POL
- x  output  10  horizontal counter, 0..H_TOTAL-1
- y  output  10  vertical counter, 0..V_TOTAL-1

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800)
  - V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK (525)
  - Both must be ≤ 1024; flag an elaboration error otherwise.
- Reset (rst low, asynchronous, no clock needed):
  - x=0, y=0, blanking=0
  - h_sync=!H_SYNC_POL, v_sync=!V_SYNC_POL (deasserted)
  - Outputs hold while rst is low.
  - The first rising edge after release advances x to 1.
- Counting:
  - x increments every clock.
  - At x=H_TOTAL-1 the next x is 0 and y increments.
  - At x=H_TOTAL-1 and y=V_TOTAL-1 the next state is (0,0).
  - No other wrap point exists; counters never exceed TOTAL-1.
- x and y are registers and are the outputs directly. They are not clamped during blanking: x runs 0..799 and y runs 0..524.
- blanking, h_sync and v_sync are registers computed from the next (x, y). They therefore describe the same pixel as the current x/y, with zero skew.
- blanking = (x ≥ H_ACTIVE) or (y ≥ V_ACTIVE).
- h_sync is asserted when H_ACTIVE+H_FRONT ≤ x < H_ACTIVE+H_FRONT+H_SYNC, i.e. x = 656..751 by default.
- v_sync is asserted when V_ACTIVE+V_FRONT ≤ y < V_ACTIVE+V_FRONT+V_SYNC, i.e. y = 490..491 by default.
- v_sync depends only on y. It changes at the x=0 boundary and stays stable for whole lines.
- Sync pulses may fall in blanking only; blanking is independent of sync state.
- Reset mid-frame: outputs return immediately to reset values. Counting restarts from (0,0) with no partial-frame artefacts.
- No other inputs exist; there is no enable or stall.
- Frame period with defaults: 420000 clocks.

Test Plan:
- Hold rst low for 5 clocks, then release → x=0, y=0, blanking=0, h_sync=1, v_sync=1 during reset; x=1 after the first edge following release.
- Run 800 clocks from (0,0) → x counts 0..799, then x=0, y=1; blanking=0 for x 0..639 and 1 for x 640..799; h_sync=0 exactly for x 656..751 (96 clocks).
- Run one full frame → y=480 first line with blanking=1 for all x; v_sync=0 exactly while y=490 and y=491 (1600 clocks); v_sync=1 elsewhere.
- Frame wrap → (799,524) is followed by (0,0) with blanking=0; two consecutive frame starts are 420000 clocks apart.
- Assert rst low asynchronously (between edges) at (300,200) → outputs go to reset values before the next edge; after release, the sequence repeats as in scenario 1.
- Set parameters H_SYNC_POL=1, V_SYNC_POL=1 → h_sync and v_sync idle low and pulse high over the same x/y ranges.

Source files
------------

// File: rtl/video_sync.sv
// Free-running raster timing generator: pixel position, blanking and sync pulses.
// Blanking and syncs are registered from the next (x, y) so they align with x/y.
module video_sync #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  output logic       blanking,
  output logic       h_sync,
  output logic       v_sync,
  output logic [9:0] x,
  output logic [9:0] y
);

  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_ACTIVE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
      $error("video_sync: H_TOTAL and V_TOTAL must not exceed 1024");
    end
  endgenerate

  logic [9:0] x_q, x_d, y_q, y_d;
  logic       blank_q, blank_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic [10:0] x_ext, y_ext;

  always_comb begin
    x_d = x_q + 10'd1;
    y_d = y_q;
    if (x_q == 10'(H_TOTAL - 1)) begin
      x_d = '0;
      if (y_q == 10'(V_TOTAL - 1)) y_d = '0;
      else                         y_d = y_q + 10'd1;
    end
    // 11-bit compares so range ends equal to 1024 stay representable
    x_ext   = {1'b0, x_d};
    y_ext   = {1'b0, y_d};
    blank_d = (x_ext >= 11'(H_ACTIVE)) || (y_ext >= 11'(V_ACTIVE));
    hs_d    = ((x_ext >= 11'(HS_START)) && (x_ext < 11'(HS_END))) ? H_SYNC_POL : ~H_SYNC_POL;
    vs_d    = ((y_ext >= 11'(VS_START)) && (y_ext < 11'(VS_END))) ? V_SYNC_POL : ~V_SYNC_POL;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q     <= '0;
      y_q     <= '0;
      blank_q <= 1'b0;
      hs_q    <= ~H_SYNC_POL;
      vs_q    <= ~V_SYNC_POL;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      blank_q <= blank_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
    end
  end

  assign x        = x_q;
  assign y        = y_q;
  assign blanking = blank_q;
  assign h_sync   = hs_q;
  assign v_sync   = vs_q;

endmodule

// File: tb/tb_video_sync.sv
// Randomized bench for video_sync: default timing plus two reduced-size rasters
// (both sync polarities) checked every pixel against a position-from-clock-count model.
module tb_video_sync;

  logic clk;
  logic rst;

  logic       d_blank, d_hs, d_vs;
  logic [9:0] d_x, d_y;
  logic       s_blank, s_hs, s_vs;
  logic [9:0] s_x, s_y;
  logic       p_blank, p_hs, p_vs;
  logic [9:0] p_x, p_y;

  int checks   = 0;
  int failures = 0;
  int n        = 0;     // clocks since reset release
  int last_frame_n = 0;

  localparam int S_HT = 8 + 2 + 3 + 2;
  localparam int S_VT = 6 + 1 + 2 + 1;

  video_sync dut_def (
    .clk(clk), .rst(rst), .blanking(d_blank), .h_sync(d_hs), .v_sync(d_vs), .x(d_x), .y(d_y)
  );

  video_sync #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
  ) dut_small (
    .clk(clk), .rst(rst), .blanking(s_blank), .h_sync(s_hs), .v_sync(s_vs), .x(s_x), .y(s_y)
  );

  video_sync #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) dut_pol (
    .clk(clk), .rst(rst), .blanking(p_blank), .h_sync(p_hs), .v_sync(p_vs), .x(p_x), .y(p_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s n=%0d got=%0d expected=%0d", tag, n, obs, exp_v);
    end
  endtask

  // Reference: the pixel shown after k clocks is simply k mod frame size.
  task automatic check_dut(input string nm, input int k,
                           input int ha, input int hf, input int hsw, input int hb,
                           input int va, input int vf, input int vsw, input int vb,
                           input bit hp, input bit vp,
                           input logic [9:0] ox, input logic [9:0] oy,
                           input logic ob, input logic ohs, input logic ovs);
    int ht, vt, p, ex, ey;
    bit eb, ehs, evs;
    ht  = ha + hf + hsw + hb;
    vt  = va + vf + vsw + vb;
    p   = k % (ht * vt);
    ex  = p % ht;
    ey  = p / ht;
    eb  = (ex >= ha) || (ey >= va);
    ehs = (ex >= ha + hf && ex < ha + hf + hsw) ? hp : !hp;
    evs = (ey >= va + vf && ey < va + vf + vsw) ? vp : !vp;
    check({nm, ".x"}, 32'(ox), 32'(ex));
    check({nm, ".y"}, 32'(oy), 32'(ey));
    check({nm, ".blank"}, 32'(ob), 32'(eb));
    check({nm, ".hsync"}, 32'(ohs), 32'(ehs));
    check({nm, ".vsync"}, 32'(ovs), 32'(evs));
  endtask

  task automatic check_all();
    check_dut("def", n, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0,
              d_x, d_y, d_blank, d_hs, d_vs);
    check_dut("small", n, 8, 2, 3, 2, 6, 1, 2, 1, 1'b0, 1'b0,
              s_x, s_y, s_blank, s_hs, s_vs);
    check_dut("pol", n, 8, 2, 3, 2, 6, 1, 2, 1, 1'b1, 1'b1,
              p_x, p_y, p_blank, p_hs, p_vs);
    if (n > 0 && s_x == 10'd0 && s_y == 10'd0) begin
      check("small.frame_period", 32'(n - last_frame_n), 32'(S_HT * S_VT));
      last_frame_n = n;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".def"},   {d_x, d_y, d_blank, d_hs, d_vs}, {10'd0, 10'd0, 1'b0, 1'b1, 1'b1});
    check({tag, ".small"}, {s_x, s_y, s_blank, s_hs, s_vs}, {10'd0, 10'd0, 1'b0, 1'b1, 1'b1});
    check({tag, ".pol"},   {p_x, p_y, p_blank, p_hs, p_vs}, {10'd0, 10'd0, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic run_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      n = n + 1;
      @(negedge clk);
      check_all();
    end
  endtask

  // Called just after a negedge: drop rst between edges, confirm outputs clear before
  // the next posedge, hold, then release away from the active edge.
  task automatic do_reset(input int hold, input string tag);
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals({tag, ".async"});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_reset_vals({tag, ".hold"});
    end
    rst = 1'b1;
    n = 0;
    last_frame_n = 0;
    check_reset_vals({tag, ".released"});
  endtask

  initial begin
    rst = 1'b1;
    #1;
    @(negedge clk);
    do_reset(5, "rst0");
    run_cycles(1);
    check("first_edge.x", 32'(d_x), 32'd1);
    run_cycles(1700);
    for (int it = 0; it < 4; it++) begin
      run_cycles(int'($urandom_range(50, 1500)));
      do_reset(int'($urandom_range(1, 6)), "rst_mid");
      run_cycles(1);
      check("restart.x", 32'(d_x), 32'd1);
    end
    run_cycles(900);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
